// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and instruction fetcher: req/gnt + rvalid toward imem, valid/ready toward decode.
// Optional macro FETCH_BYPASS_EN forwards imem read data straight to decode in the data-return cycle.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      npc_i,
    input  logic             halt_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [31:0]      inst_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pcplus4_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] inst_cnt_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        retire       = 1'b0;
        imem_req_o   = 1'b0;
        inst_valid_o = 1'b0;
        inst_o       = inst_q;

        case (state_q)
            S_REQ: begin
                // rstn gating keeps req low while the async reset is held.
                imem_req_o = ~halt_i & ~fault_q & rstn;
                if (imem_req_o && imem_gnt_i)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    inst_d = imem_rdata_i;
`ifdef FETCH_BYPASS_EN
                    inst_valid_o = 1'b1;
                    inst_o       = imem_rdata_i;
                    if (inst_ready_i)
                        retire = 1'b1;
                    else
                        state_d = S_HOLD;
`else
                    state_d = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i)
                    retire = 1'b1;
            end
            default: state_d = S_REQ;
        endcase

        // A misaligned target still counts as retired but freezes the PC and stops fetching.
        if (retire) begin
            state_d = S_REQ;
            cnt_d   = cnt_q + CNT_W'(1);
            if (npc_i[1:0] != 2'b00)
                fault_d = 1'b1;
            else
                pc_d = npc_i;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign pcplus4_o   = pc_q + 32'd4;
    assign fault_o     = fault_q;
    assign inst_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized fetch traffic vs. a transaction model.
module tb_pc_fetch_unit;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int          T1_CYC   = 6;
`else
    localparam int          T1_CYC   = 9;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic [31:0]      npc_i;
    logic             halt_i;
    logic             imem_req_o;
    logic [31:0]      imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [31:0]      imem_rdata_i;
    logic             inst_valid_o;
    logic             inst_ready_i;
    logic [31:0]      inst_o;
    logic [31:0]      pc_o;
    logic [31:0]      pcplus4_o;
    logic             fault_o;
    logic [CNT_W-1:0] inst_cnt_o;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .npc_i(npc_i), .halt_i(halt_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .pc_o(pc_o), .pcplus4_o(pcplus4_o), .fault_o(fault_o), .inst_cnt_o(inst_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: architectural PC, sticky fault, number of retirements.
    logic [31:0] m_pc;
    bit          m_fault;
    int          m_retired;

    function automatic logic [31:0] m_cnt();
        return 32'(m_retired % (1 << CNT_W));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_fault   = 1'b0;
        m_retired = 0;
    endtask

    task automatic model_retire(input logic [31:0] npc);
        m_retired++;
        if (npc[1:0] != 2'b00) m_fault = 1'b1;
        else                   m_pc    = npc;
    endtask

    // One full instruction: gnt after gd cycles, rvalid rd cycles after gnt, decode accepts after yd cycles.
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] npc,
                             input int gd, input int rd, input int yd);
        int w;
        w = 0;
        halt_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
        #1;
        while (imem_req_o !== 1'b1 && w < 20) begin tick(); w++; end
        chk("req_seen", {31'b0, imem_req_o}, 32'd1);
        if (imem_req_o !== 1'b1) return;
        repeat (gd) begin
            imem_rvalid_i = 1'b1; imem_rdata_i = $urandom;  // stale beat, must be ignored
            #1;
            chk("req_hold", {31'b0, imem_req_o}, 32'd1);
            chk("addr_hold", imem_addr_o, m_pc);
            tick();
        end
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        #1;
        chk("fetch_addr", imem_addr_o, m_pc);
        tick();
        imem_gnt_i = 1'b0;
        repeat (rd) begin
            #1;
            chk("wait_noreq", {31'b0, imem_req_o}, 32'd0);
            chk("wait_novalid", {31'b0, inst_valid_o}, 32'd0);
            tick();
        end
        imem_rvalid_i = 1'b1; imem_rdata_i = data;
        tick();
        imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
        repeat (yd) begin
            imem_rvalid_i = 1'($urandom_range(0, 1));
            imem_rdata_i  = $urandom;
            #1;
            chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("hold_inst", inst_o, data);
            chk("hold_pc", pc_o, m_pc);
            chk("hold_noreq", {31'b0, imem_req_o}, 32'd0);
            chk("hold_cnt", {28'b0, inst_cnt_o}, m_cnt());
            tick();
        end
        imem_rvalid_i = 1'b0; inst_ready_i = 1'b1; npc_i = npc;
        #1;
        chk("ret_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("ret_inst", inst_o, data);
        chk("ret_pc", pc_o, m_pc);
        chk("ret_pc4", pcplus4_o, m_pc + 32'd4);
        tick();
        inst_ready_i = 1'b0;
        model_retire(npc);
        #1;
        chk("post_cnt", {28'b0, inst_cnt_o}, m_cnt());
        chk("post_fault", {31'b0, fault_o}, {31'b0, m_fault});
        chk("post_pc", pc_o, m_pc);
        chk("post_req", {31'b0, imem_req_o}, {31'b0, !m_fault});
    endtask

    initial begin
        logic [31:0] addrs[$];
        logic [31:0] r;
        logic [31:0] npc;

        rstn = 1'b0; halt_i = 1'b0; npc_i = '0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF; inst_ready_i = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_fault", {31'b0, fault_o}, 32'd0);
        chk("rst_cnt", {28'b0, inst_cnt_o}, 32'd0);

        // Back-to-back stream with an immediate memory and decode.
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; inst_ready_i = 1'b1; rstn = 1'b1;
        for (int c = 0; c < T1_CYC; c++) begin
            npc_i = pc_o + 32'd4;
            imem_rdata_i = 32'h1000 + 32'(c);
            #1;
            if (imem_req_o && imem_gnt_i) addrs.push_back(imem_addr_o);
            tick();
        end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
        chk("t1_nreq", 32'(addrs.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("t1_addr", (i < addrs.size()) ? addrs[i] : 32'hX, 32'(4 * i));
        m_retired = 3; m_pc = 32'd12;
        chk("t1_cnt", {28'b0, inst_cnt_o}, m_cnt());
        chk("t1_pc", pc_o, m_pc);

        // Branch target.
        fetch_one(32'hAAAA_0001, 32'h0000_0040, 0, 0, 0);
        chk("br_addr", imem_addr_o, 32'h40);
        chk("br_pc4", pcplus4_o, 32'h44);

        // Decode stalls five cycles.
        fetch_one(32'hBBBB_0002, 32'h0000_0044, 1, 1, 5);

        // Halt in S_REQ.
        halt_i = 1'b1;
        repeat (4) begin
            #1;
            chk("halt_noreq", {31'b0, imem_req_o}, 32'd0);
            tick();
        end
        halt_i = 1'b0;
        #1;
        chk("halt_rel_req", {31'b0, imem_req_o}, 32'd1);
        chk("halt_rel_addr", imem_addr_o, m_pc);

        // Top-of-memory PC: pc+4 wraps to zero.
        fetch_one(32'hCCCC_0003, 32'hFFFF_FFFC, 0, 0, 0);
        chk("wrap_pc4", pcplus4_o, 32'h0);
        fetch_one(32'hCCCC_0004, 32'h0000_0000, 0, 0, 0);

        // Randomized traffic, aligned targets only; also carries the counter through its wrap.
        for (int n = 0; n < 30; n++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       npc = m_pc + 32'd4;
                1:       npc = r & 32'hFFFF_FFFC;
                default: npc = (m_pc + (r & 32'h0000_00FC)) & 32'hFFFF_FFFC;
            endcase
            fetch_one($urandom, npc, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("wrap_cnt_seen", {31'b0, 1'(m_retired >= 16)}, 32'd1);

        // Misaligned target: sticky fault, no further requests.
        fetch_one(32'hDDDD_0005, 32'h0000_0042, 0, 0, 1);
        imem_gnt_i = 1'b1;
        repeat (4) begin
            #1;
            chk("fault_noreq", {31'b0, imem_req_o}, 32'd0);
            chk("fault_pc", pc_o, m_pc);
            tick();
        end
        imem_gnt_i = 1'b0;

        // Reset clears the fault; then reset again while a fetch is outstanding.
        rstn = 1'b0; model_reset();
        tick();
        rstn = 1'b1;
        #1;
        chk("rst2_fault", {31'b0, fault_o}, 32'd0);
        chk("rst2_req", {31'b0, imem_req_o}, 32'd1);
        fetch_one(32'hEEEE_0006, 32'h0000_0100, 0, 0, 0);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #2;
        rstn = 1'b0; model_reset();
        #1;
        chk("rstw_pc", pc_o, RESET_PC);
        chk("rstw_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        rstn = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_AAAA;
        #1;
        chk("rstw_drop_valid", {31'b0, inst_valid_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        chk("rstw_novalid", {31'b0, inst_valid_o}, 32'd0);
        chk("rstw_inst", inst_o, 32'h0);
        chk("rstw_freq", {31'b0, imem_req_o}, 32'd1);
        chk("rstw_addr", imem_addr_o, RESET_PC);
        fetch_one(32'hFFFF_0007, 32'h0000_0004, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
